// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame
// geometry used by the transmitter, receiver and baud generator.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RESET_VALUE lets an idle-high line come out of reset without a false edge.
module rx_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/stop validation and LSB-first
// assembly of DATA_BITS data bits into a parallel word.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a low sample on a tick
// RX_START | counting to mid start bit to reject glitches
// RX_DATA  | sampling data bits at mid bit, every OVERSAMPLE ticks
// RX_STOP  | sampling stop bit; high delivers the word, low is a framing error
// RX_BREAK | line held low after a framing error; wait for it to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS + 1);

  localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS);

  rx_state_e            state, state_nxt;
  logic [TCNT_W-1:0]    tcnt, tcnt_nxt;
  logic [BCNT_W-1:0]    bcnt, bcnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt;
  logic                 frame_err_nxt;
  logic                 rxd_s;

  rx_sync #(
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clock (clock),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= RX_IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      tcnt      <= tcnt_nxt;
      bcnt      <= bcnt_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tcnt_nxt      = tcnt;
    bcnt_nxt      = bcnt;
    shreg_nxt     = shreg;
    data_nxt      = data;
    valid_nxt     = 1'b0;
    frame_err_nxt = 1'b0;

    case (state)
      RX_IDLE: begin
        if (tick && !rxd_s) begin
          tcnt_nxt  = '0;
          state_nxt = RX_START;
        end
      end

      RX_START: begin
        if (tick) begin
          if (tcnt == TCNT_MID) begin
            tcnt_nxt = '0;
            if (!rxd_s) begin
              bcnt_nxt  = '0;
              state_nxt = RX_DATA;
            end else begin
              state_nxt = RX_IDLE;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (tick) begin
          if (tcnt == TCNT_LAST) begin
            // Shift right so the first (LSB) bit received lands at bit 0.
            shreg_nxt = {rxd_s, shreg[DATA_BITS-1:1]};
            bcnt_nxt  = bcnt + 1'b1;
            tcnt_nxt  = '0;
            if (bcnt + 1'b1 == BCNT_LAST) begin
              state_nxt = RX_STOP;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (tick) begin
          if (tcnt == TCNT_LAST) begin
            tcnt_nxt = '0;
            if (rxd_s) begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
              state_nxt = RX_IDLE;
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = RX_BREAK;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end

      // Exits on the line level alone so a long break yields a single error.
      RX_BREAK: begin
        if (rxd_s) begin
          state_nxt = RX_IDLE;
        end
      end

      default: begin
        state_nxt = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state != RX_IDLE);
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive block for the UART link: the receiving end of the frames the transmit side produces (1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity). It oversamples the asynchronous `rxd` line using an external tick, validates start and stop bits, and assembles the data bits into a parallel word. It delivers each word as a one-cycle `valid` pulse to the downstream consumer (display or loopback logic).

## Interface
- `DATA_BITS`, 8, data bits per frame.
- `OVERSAMPLE`, 16, ticks per bit period; even, ≥ 4.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `tick`  in  1  one-cycle strobe at OVERSAMPLE × baud rate, from the baud generator.
- `rxd`  in  1  asynchronous serial input; idle high.
- `data`  out  DATA_BITS  last correctly framed word; holds until the next good frame.
- `valid`  out  1  one-cycle pulse: `data` has just been updated.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high in every state except RX_IDLE.

## Operation
- Synchronize `rxd` through two flops, both reset to 1. All FSM decisions use the second flop (`rxd_s`).
- The FSM and counters advance only on cycles where `tick`=1. Exception: RX_BREAK exits on `rxd_s` regardless of `tick`.
- The tick counter `tcnt` is $clog2(OVERSAMPLE) bits. The bit counter `bcnt` is $clog2(DATA_BITS+1) bits.
- RX_IDLE: on a tick with `rxd_s`=0, clear `tcnt` and go to RX_START.
- RX_START: count ticks. On the tick where `tcnt` = OVERSAMPLE/2−1 (mid start bit):
  - `rxd_s`=0: clear `tcnt` and `bcnt`, go to RX_DATA.
  - `rxd_s`=1: glitch; go to RX_IDLE with no output.
- RX_DATA: on the tick where `tcnt` = OVERSAMPLE−1:
  - Shift `rxd_s` into the MSB of the shift register (shift right), so the first bit received ends at bit 0.
  - Increment `bcnt` and clear `tcnt`.
  - When `bcnt` reaches DATA_BITS, go to RX_STOP.
- RX_STOP: on the tick where `tcnt` = OVERSAMPLE−1:
  - `rxd_s`=1: load `data` from the shift register, pulse `valid`, go to RX_IDLE.
  - `rxd_s`=0: pulse `frame_err`, leave `data` unchanged, go to RX_BREAK.
- RX_BREAK: wait for `rxd_s`=1, then go to RX_IDLE. A held-low line (break) never produces more than one `frame_err`.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `busy`=0, state RX_IDLE, counters 0, shift register 0, synchronizer flops 1.
- Reset has priority over `tick` and `rxd` in the same cycle.
- Reset mid-frame discards the partial word; `data` returns to 0.
- Input latency: 2 clocks from `rxd` to `rxd_s`.
- Sample points fall OVERSAMPLE/2 ticks after the detected falling edge, then every OVERSAMPLE ticks.
- `valid` / `frame_err` are registered and go high the clock after the stop-bit sampling tick, for exactly one clock.
- Back-to-back frames: RX_IDLE is re-entered at mid stop bit, so a start bit beginning exactly one bit period after the stop-bit start is caught.
- `tcnt` wraps to 0 explicitly at each sample point; it never free-runs through its maximum value.
- With no `tick`, the state never changes, except the RX_BREAK exit.

## Structure
- Shared package `uart_pkg`:
  - state encodings RX_IDLE=0, RX_START=1, RX_DATA=2, RX_STOP=3, RX_BREAK=4 (3 bits);
  - default DATA_BITS and OVERSAMPLE, shared with the transmit side and the baud generator.
- One sub-module, `rx_sync`: the 2-flop synchronizer with a reset value parameter.
- The FSM, counters and shift register stay in `uart_rx`, with separate registered-state and combinational next-state processes.

## Test plan
All scenarios use DATA_BITS=8, OVERSAMPLE=16, and `tick` every 4 clocks.
- Frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) -> one `valid` pulse, `data`=0xA5, `frame_err` never high, `busy` falls after stop sample.
- `rxd` low for 4 ticks, then high -> no `valid`, FSM back in RX_IDLE, `data` unchanged.
- After 0xA5, send frame 0x3C with stop bit 0, then hold `rxd` low for 40 bit times -> exactly one `frame_err` pulse, `data` stays 0xA5, no further activity until `rxd` high; next frame 0x81 -> `valid`, `data`=0x81.
- Back-to-back 0x00 then 0xFF with a one-bit stop -> two `valid` pulses, `data`=0x00 then 0xFF.
- Assert `reset` during data bit 4 of frame 0x77 -> all outputs 0 the next cycle, no `valid`; following frame 0x5A -> `data`=0x5A.
- `tick` held 0 while `rxd` toggles -> FSM remains in RX_IDLE, all outputs at reset values.
